// File: rtl/matrix_op_sequencer.sv
// Byte-serial command/operand loader and result streamer wrapped around the 5x5 matrix ALU.
// Operands are packed as element (r,c) at byte 5r+c; determinant results stream as five LSB-first bytes.
module matrix_op_sequencer #(
  parameter int SEQ_WAIT = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [1:0]   cmd_size,
  input  logic [7:0]   cmd_scalar,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [7:0]   in_data,
  output logic [2:0]   op_code,
  output logic [1:0]   matrix_size,
  output logic [7:0]   scalar,
  output logic [199:0] matrix_a,
  output logic [199:0] matrix_b,
  output logic         alu_start,
  input  logic [199:0] alu_result,
  input  logic         alu_overflow,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [7:0]   out_data,
  output logic         out_last,
  output logic         out_overflow,
  output logic         err
);

  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, START, WAIT, SEND} state_t;

  state_t         state_q, state_d;
  logic [2:0]     row_q, row_d, col_q, col_d;
  logic [15:0]    wait_q, wait_d;
  logic [199:0]   result_q, result_d;
  logic           ovf_q, ovf_d;
  logic [2:0]     op_q, op_d;
  logic [1:0]     size_q, size_d;
  logic [7:0]     scalar_q, scalar_d;
  logic [199:0]   mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic           cmd_ready_q, cmd_ready_d, in_ready_q, in_ready_d;
  logic           alu_start_q, alu_start_d, err_q, err_d;
  logic           out_valid_q, out_valid_d, out_last_q, out_last_d, out_ovf_q, out_ovf_d;
  logic [7:0]     out_data_q, out_data_d;

  logic [2:0]     n, send_rows, send_len;
  logic           is_det, two_operand, seq_op, load_last;
  logic [4:0]     pos_d;

  function automatic logic [4:0] pos_of(input logic [2:0] r, input logic [2:0] c);
    logic [4:0] p;
    p = ({2'b00, r} * 5'd5) + {2'b00, c};
    return p;
  endfunction

  assign cmd_ready    = cmd_ready_q;
  assign in_ready     = in_ready_q;
  assign op_code      = op_q;
  assign matrix_size  = size_q;
  assign scalar       = scalar_q;
  assign matrix_a     = mat_a_q;
  assign matrix_b     = mat_b_q;
  assign alu_start    = alu_start_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_last     = out_last_q;
  assign out_overflow = out_ovf_q;
  assign err          = err_q;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    col_d    = col_q;
    wait_d   = wait_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    op_d     = op_q;
    size_d   = size_q;
    scalar_d = scalar_q;
    mat_a_d  = mat_a_q;
    mat_b_d  = mat_b_q;
    err_d    = 1'b0;

    n           = {1'b0, size_q} + 3'd2;
    is_det      = (op_q == 3'b101);
    two_operand = (op_q == 3'b000) || (op_q == 3'b001) || (op_q == 3'b110);
    seq_op      = (op_q == 3'b101) || (op_q == 3'b110);
    // The determinant is walked as a single row of five bytes so one counter pair serves both shapes.
    send_rows   = is_det ? 3'd1 : n;
    send_len    = is_det ? 3'd5 : n;
    load_last   = (row_q == n - 3'd1) && (col_q == n - 3'd1);

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_op == 3'b111) begin
            err_d = 1'b1;
          end else begin
            op_d     = cmd_op;
            size_d   = cmd_size;
            scalar_d = cmd_scalar;
            mat_a_d  = '0;
            mat_b_d  = '0;
            row_d    = '0;
            col_d    = '0;
            state_d  = LOAD_A;
          end
        end
      end
      LOAD_A, LOAD_B: begin
        if (in_valid && in_ready_q) begin
          if (state_q == LOAD_A) mat_a_d[{pos_of(row_q, col_q), 3'b000} +: 8] = in_data;
          else                   mat_b_d[{pos_of(row_q, col_q), 3'b000} +: 8] = in_data;
          if (load_last) begin
            row_d   = '0;
            col_d   = '0;
            state_d = (state_q == LOAD_A && two_operand) ? LOAD_B : START;
          end else if (col_q == n - 3'd1) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      START: begin
        wait_d  = seq_op ? 16'(SEQ_WAIT - 1) : 16'd0;
        state_d = WAIT;
      end
      WAIT: begin
        if (wait_q == 16'd0) begin
          result_d = alu_result;
          ovf_d    = alu_overflow;
          row_d    = '0;
          col_d    = '0;
          state_d  = SEND;
        end else begin
          wait_d = wait_q - 16'd1;
        end
      end
      SEND: begin
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            row_d   = '0;
            col_d   = '0;
            state_d = IDLE;
          end else if (col_q == send_len - 3'd1) begin
            col_d = '0;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with the state they describe.
    pos_d       = pos_of(row_d, col_d);
    cmd_ready_d = (state_d == IDLE);
    in_ready_d  = (state_d == LOAD_A) || (state_d == LOAD_B);
    alu_start_d = (state_d == START);
    out_valid_d = (state_d == SEND);
    out_data_d  = out_valid_d ? result_d[{pos_d, 3'b000} +: 8] : 8'd0;
    out_last_d  = out_valid_d && (row_d == send_rows - 3'd1) && (col_d == send_len - 3'd1);
    out_ovf_d   = out_valid_d && ovf_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      wait_q      <= '0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      op_q        <= '0;
      size_q      <= '0;
      scalar_q    <= '0;
      mat_a_q     <= '0;
      mat_b_q     <= '0;
      cmd_ready_q <= 1'b0;
      in_ready_q  <= 1'b0;
      alu_start_q <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wait_q      <= wait_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      op_q        <= op_d;
      size_q      <= size_d;
      scalar_q    <= scalar_d;
      mat_a_q     <= mat_a_d;
      mat_b_q     <= mat_b_d;
      cmd_ready_q <= cmd_ready_d;
      in_ready_q  <= in_ready_d;
      alu_start_q <= alu_start_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

endmodule
